// File: rtl/rx_cmd_decoder_pkg.sv
// Shared definitions for the RX command decoder: command codes (common with the TX controller),
// start-of-frame codes, ALU operand register addresses and the decoder FSM/frame types.
// No timing or backpressure of its own.
package rx_cmd_decoder_pkg;

    localparam logic [2:0] CMD_NONE    = 3'b000;
    localparam logic [2:0] CMD_WRITE   = 3'b001;
    localparam logic [2:0] CMD_READ    = 3'b010;
    localparam logic [2:0] CMD_OPERAND = 3'b011;
    localparam logic [2:0] CMD_ALU     = 3'b100;

    localparam logic [7:0] SOF_WRITE   = 8'hAA;
    localparam logic [7:0] SOF_READ    = 8'hBB;
    localparam logic [7:0] SOF_ALU_OPS = 8'hCC;
    localparam logic [7:0] SOF_ALU     = 8'hDD;

    localparam logic [7:0] OPA_ADDR    = 8'h00;
    localparam logic [7:0] OPB_ADDR    = 8'h01;

    typedef enum logic [2:0] {
        WAIT_SOF,
        GET_ADDR,
        GET_DATA,
        GET_OPA,
        GET_OPB,
        GET_FUN,
        ISSUE,
        SEQ
    } dec_state_t;

    typedef enum logic [1:0] {
        FR_WRITE,
        FR_READ,
        FR_ALU_OPS,
        FR_ALU
    } frame_t;

    function automatic logic is_get_state(input dec_state_t s);
        return (s == GET_ADDR) || (s == GET_DATA) || (s == GET_OPA) ||
               (s == GET_OPB)  || (s == GET_FUN);
    endfunction

endpackage

// File: rtl/rx_cmd_decoder_gap_timer.sv
// Inter-byte gap timer: counts enabled idle cycles, strobes expire on the GAP_CYCLES-th one.
// Latency: expire is combinational from the registered count; clear always wins over expire.
// No backpressure; clear/enable are sampled every cycle.
module rx_gap_timer #(
    parameter int GAP_CYCLES = 2048,
    parameter int GAP_W      = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [GAP_W-1:0] cnt_q;

    assign expire = en && !clr && (cnt_q == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || !en || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/rx_cmd_decoder.sv
// Collects UART RX bytes into command frames and issues 1-3 step command sequences to the TX controller.
// Latency: first step two cycles after the last byte when Ctrl_Ready is already high; all outputs registered.
// Backpressure: Ctrl_Ready gates only the first step; bytes arriving while a frame is pending are dropped.
import rx_cmd_decoder_pkg::*;

module rx_cmd_decoder #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2048,
    parameter int GAP_W      = 12
) (
    input  logic              RXDec_CLK,
    input  logic              RXDec_RST,
    input  logic [DATA_W-1:0] RXDec_RxData,
    input  logic              RXDec_RxValid,
    input  logic              RXDec_RxErr,
    input  logic              RXDec_Ctrl_Ready,
    output logic [2:0]        RXDec_command,
    output logic [DATA_W-1:0] RXDec_Addr,
    output logic [DATA_W-1:0] RXDec_Pdata,
    output logic              RXDec_Frame_Drop
);

    dec_state_t        state_q, state_d;
    frame_t            frame_q, frame_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [3:0]        fun_q, fun_d;
    logic [1:0]        step_q, step_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [DATA_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              drop_q, drop_d;
    logic              gap_expire;

    rx_gap_timer #(
        .GAP_CYCLES (GAP_CYCLES),
        .GAP_W      (GAP_W)
    ) u_gap_timer (
        .clk    (RXDec_CLK),
        .rst_n  (RXDec_RST),
        .clr    (RXDec_RxValid),
        .en     (is_get_state(state_q)),
        .expire (gap_expire)
    );

    always_ff @(posedge RXDec_CLK or negedge RXDec_RST) begin
        if (!RXDec_RST) begin
            state_q <= WAIT_SOF;
            frame_q <= FR_WRITE;
            addr_q  <= '0;
            data_q  <= '0;
            opb_q   <= '0;
            fun_q   <= '0;
            step_q  <= '0;
            cmd_q   <= CMD_NONE;
            oaddr_q <= '0;
            pdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            opb_q   <= opb_d;
            fun_q   <= fun_d;
            step_q  <= step_d;
            cmd_q   <= cmd_d;
            oaddr_q <= oaddr_d;
            pdata_q <= pdata_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        addr_d  = addr_q;
        data_d  = data_q;
        opb_d   = opb_q;
        fun_d   = fun_q;
        step_d  = step_q;
        cmd_d   = CMD_NONE;
        oaddr_d = '0;
        pdata_d = '0;
        drop_d  = 1'b0;

        unique case (state_q)
            WAIT_SOF: begin
                step_d = '0;
                // Unknown bytes and errored bytes between frames are silently skipped.
                if (RXDec_RxValid && !RXDec_RxErr) begin
                    if (RXDec_RxData == DATA_W'(SOF_WRITE)) begin
                        frame_d = FR_WRITE;
                        state_d = GET_ADDR;
                    end else if (RXDec_RxData == DATA_W'(SOF_READ)) begin
                        frame_d = FR_READ;
                        state_d = GET_ADDR;
                    end else if (RXDec_RxData == DATA_W'(SOF_ALU_OPS)) begin
                        frame_d = FR_ALU_OPS;
                        state_d = GET_OPA;
                    end else if (RXDec_RxData == DATA_W'(SOF_ALU)) begin
                        frame_d = FR_ALU;
                        state_d = GET_FUN;
                    end
                end
            end
            GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUN: begin
                if (RXDec_RxErr) begin
                    state_d = WAIT_SOF;
                    drop_d  = 1'b1;
                end else if (RXDec_RxValid) begin
                    case (state_q)
                        GET_ADDR: begin
                            addr_d  = RXDec_RxData;
                            state_d = (frame_q == FR_WRITE) ? GET_DATA : ISSUE;
                        end
                        GET_DATA: begin
                            data_d  = RXDec_RxData;
                            state_d = ISSUE;
                        end
                        GET_OPA: begin
                            data_d  = RXDec_RxData;
                            state_d = GET_OPB;
                        end
                        GET_OPB: begin
                            opb_d   = RXDec_RxData;
                            state_d = GET_FUN;
                        end
                        default: begin
                            fun_d   = RXDec_RxData[3:0];
                            state_d = ISSUE;
                        end
                    endcase
                end else if (gap_expire) begin
                    state_d = WAIT_SOF;
                    drop_d  = 1'b1;
                end
            end
            ISSUE: begin
                drop_d = RXDec_RxValid;
                if (RXDec_Ctrl_Ready) begin
                    state_d = SEQ;
                    step_d  = '0;
                end
            end
            SEQ: begin
                drop_d  = RXDec_RxValid;
                step_d  = step_q + 2'd1;
                state_d = WAIT_SOF;
                unique case (frame_q)
                    FR_WRITE: begin
                        cmd_d   = CMD_WRITE;
                        oaddr_d = addr_q;
                        pdata_d = data_q;
                    end
                    FR_READ: begin
                        cmd_d   = CMD_READ;
                        oaddr_d = addr_q;
                    end
                    FR_ALU_OPS: begin
                        case (step_q)
                            2'd0: begin
                                cmd_d   = CMD_OPERAND;
                                oaddr_d = DATA_W'(OPA_ADDR);
                                pdata_d = data_q;
                                state_d = SEQ;
                            end
                            2'd1: begin
                                cmd_d   = CMD_WRITE;
                                oaddr_d = DATA_W'(OPB_ADDR);
                                pdata_d = opb_q;
                                state_d = SEQ;
                            end
                            default: begin
                                cmd_d   = CMD_ALU;
                                pdata_d = DATA_W'(fun_q);
                            end
                        endcase
                    end
                    FR_ALU: begin
                        cmd_d   = CMD_ALU;
                        pdata_d = DATA_W'(fun_q);
                    end
                endcase
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    assign RXDec_command    = cmd_q;
    assign RXDec_Addr       = oaddr_q;
    assign RXDec_Pdata      = pdata_q;
    assign RXDec_Frame_Drop = drop_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: expected command steps queued with their issue cycle,
// popped by a negedge monitor; drop pulses counted and compared at checkpoints.
module tb_rx_cmd_decoder;

    localparam int GAP = 2048;

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] addr;
        logic [7:0] pdata;
        int         at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_err;
    logic       ready;
    logic [2:0] cmd;
    logic [7:0] addr;
    logic [7:0] pdata;
    logic       drop;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   drop_seen = 0;
    int   exp_drop = 0;
    int   r;
    exp_t q[$];
    exp_t mon_e;

    rx_cmd_decoder #(
        .DATA_W     (8),
        .GAP_CYCLES (GAP),
        .GAP_W      (12)
    ) dut (
        .RXDec_CLK        (clk),
        .RXDec_RST        (rst_n),
        .RXDec_RxData     (rx_data),
        .RXDec_RxValid    (rx_vld),
        .RXDec_RxErr      (rx_err),
        .RXDec_Ctrl_Ready (ready),
        .RXDec_command    (cmd),
        .RXDec_Addr       (addr),
        .RXDec_Pdata      (pdata),
        .RXDec_Frame_Drop (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (drop === 1'b1) drop_seen++;
            if (cmd !== 3'b000) begin
                chk("unexpected_cmd", {29'd0, cmd} & {32{q.size() == 0}}, 32'd0);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("step", {13'd0, cmd, addr, pdata}, {13'd0, mon_e.cmd, mon_e.addr, mon_e.pdata});
                    chk("step_cycle", cyc, mon_e.at);
                end
            end else begin
                chk("idle_zero", {16'd0, addr, pdata}, 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic err);
        rx_data = b;
        rx_vld  = 1'b1;
        rx_err  = err;
        @(negedge clk);
        rx_vld   = 1'b0;
        rx_err   = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic push(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d, input int at);
        exp_t e;
        e.cmd = c; e.addr = a; e.pdata = d; e.at = at;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, q.size(), 0);
        repeat (4) @(negedge clk);
        chk({tag, "_drop"}, drop_seen, exp_drop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rx_data = '0; rx_vld = 1'b0; rx_err = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd", cmd, 0);
        chk("rst_addr", addr, 0);
        chk("rst_pdata", pdata, 0);
        chk("rst_drop", drop, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // RF write with controller ready: single step, two cycles after the last byte
        send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0);
        push(3'b001, 8'h05, 8'h3C, last_cyc + 2);
        drain("write");

        // ALU with operands held off by Ready=0
        ready = 1'b0;
        send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h01, 0);
        repeat (10) @(negedge clk);
        ready = 1'b1;
        r = cyc;
        push(3'b011, 8'h00, 8'h12, r + 2);
        push(3'b001, 8'h01, 8'h34, r + 3);
        push(3'b100, 8'h00, 8'h01, r + 4);
        drain("alu_ops");

        // Gap of exactly GAP idle cycles aborts the frame
        send(8'hAA, 0); send(8'h07, 0);
        repeat (GAP) @(negedge clk);
        exp_drop++;
        repeat (2) @(negedge clk);
        chk("gap_drop", drop_seen, exp_drop);
        send(8'hBB, 0); send(8'h07, 0);
        push(3'b010, 8'h07, 8'h00, last_cyc + 2);
        drain("read_after_gap");

        // Byte arriving on the last allowed cycle is accepted
        send(8'hAA, 0); send(8'h07, 0);
        repeat (GAP - 1) @(negedge clk);
        send(8'h99, 0);
        push(3'b001, 8'h07, 8'h99, last_cyc + 2);
        drain("gap_edge");

        // RX error on an address byte
        send(8'hBB, 0); send(8'h07, 1);
        exp_drop++;
        repeat (3) @(negedge clk);
        chk("rxerr_drop", drop_seen, exp_drop);
        send(8'hDD, 0); send(8'h0F, 0);
        push(3'b100, 8'h00, 8'h0F, last_cyc + 2);
        drain("alu_after_err");

        // Overrun while pending; FUN upper nibble ignored
        ready = 1'b0;
        send(8'hDD, 0); send(8'hF2, 0);
        send(8'h55, 0);
        exp_drop++;
        repeat (3) @(negedge clk);
        chk("overrun_drop", drop_seen, exp_drop);
        ready = 1'b1;
        r = cyc;
        push(3'b100, 8'h00, 8'h02, r + 2);
        drain("overrun_issue");

        // Junk and errored bytes between frames are ignored silently
        send(8'h11, 0); send(8'h42, 0); send(8'hAA, 1);
        send(8'hDD, 0); send(8'h03, 0);
        push(3'b100, 8'h00, 8'h03, last_cyc + 2);
        drain("junk_ignored");

        // Reset during the second step of an ALU-with-operands sequence
        send(8'hCC, 0); send(8'h12, 0); send(8'h34, 0); send(8'h01, 0);
        r = last_cyc;
        push(3'b011, 8'h00, 8'h12, r + 2);
        push(3'b001, 8'h01, 8'h34, r + 3);
        while (cyc < r + 3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_cmd", cmd, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_pdata", pdata, 0);
        chk("midrst_drop", drop, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_q", q.size(), 0);
        send(8'h11, 0);
        send(8'hAA, 0); send(8'h20, 0); send(8'h5A, 0);
        push(3'b001, 8'h20, 8'h5A, last_cyc + 2);
        drain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
